// File: rtl/fp_toi_seq.sv
// Issue/retire sequencer for FSTOI/FDTOI. Steers each accepted request to the
// single or double converter, tracks it through a private 6-stage tag pipe,
// and collects results in issue order into a credit-managed result FIFO.
module fp_toi_seq #(
  parameter int unsigned TID_W = 5,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_dbl,
  input  logic [TID_W-1:0] req_tid,
  input  logic [63:0]      req_op,
  output logic             s_en,
  output logic [31:0]      s_din,
  input  logic [31:0]      s_dout,
  input  logic             s_rdy,
  input  logic             s_ovf,
  input  logic             s_inv,
  output logic             d_en,
  output logic [63:0]      d_din,
  input  logic [31:0]      d_dout,
  input  logic             d_rdy,
  input  logic             d_ovf,
  input  logic             d_inv,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [TID_W-1:0] res_tid,
  output logic [31:0]      res_data,
  output logic [4:0]       res_cexc,
  output logic             err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  // Wide enough for fifo_count + inflight (at most DEPTH + 6).
  localparam int unsigned SW = CW + 1;
  localparam int unsigned NSTG = 6;

  logic                acc;
  logic [2:0]          inflight;
  logic [NSTG-1:0]     tag_v_q;
  logic [NSTG-1:0]     tag_dbl_q;
  logic [TID_W-1:0]    tag_tid_q [NSTG];

  logic [31:0]         mem_data_q [DEPTH];
  logic [TID_W-1:0]    mem_tid_q  [DEPTH];
  logic [4:0]          mem_cexc_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q;
  logic [PW-1:0]       rd_ptr_q;
  logic [CW-1:0]       count_q;

  logic                push;
  logic                pop;
  logic [31:0]         push_data;
  logic [4:0]          push_cexc;
  logic                rdy_bad;
  logic                mask_q;
  logic                err_q;

  // Credit from registered state only, then issue steering.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < NSTG; i++) begin
      inflight = inflight + {2'b00, tag_v_q[i]};
    end
    req_ready = (SW'(count_q) + SW'(inflight)) < SW'(DEPTH);
    // Nothing issues while the converters are held in reset.
    acc   = req_valid & req_ready & ~rst;
    s_en  = acc & ~req_dbl;
    d_en  = acc & req_dbl;
    s_din = req_op[31:0];
    d_din = req_op;
  end

  // Tag pipe mirrors the converter latency; stage 6 (index 5) is the retire point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v_q   <= '0;
      tag_dbl_q <= '0;
      for (int i = 0; i < NSTG; i++) begin
        tag_tid_q[i] <= '0;
      end
    end else begin
      tag_v_q      <= {tag_v_q[NSTG-2:0], acc};
      tag_dbl_q    <= {tag_dbl_q[NSTG-2:0], req_dbl};
      tag_tid_q[0] <= req_tid;
      for (int i = 1; i < NSTG; i++) begin
        tag_tid_q[i] <= tag_tid_q[i-1];
      end
    end
  end

  // FIFO head outputs; data fields read as zero while empty.
  always_comb begin
    res_valid = (count_q != '0);
    res_data  = res_valid ? mem_data_q[rd_ptr_q] : '0;
    res_tid   = res_valid ? mem_tid_q[rd_ptr_q]  : '0;
    res_cexc  = res_valid ? mem_cexc_q[rd_ptr_q] : '0;
    err       = err_q;
  end

  // Retire selection and converter rdy cross-check.
  always_comb begin
    push      = tag_v_q[NSTG-1];
    pop       = res_valid & res_ready;
    push_data = tag_dbl_q[NSTG-1] ? d_dout : s_dout;
    // Overflow and NaN/inf both map to NV; the other flags never assert.
    push_cexc = {tag_dbl_q[NSTG-1] ? (d_inv | d_ovf) : (s_inv | s_ovf), 4'b0000};
    rdy_bad   = (s_rdy != (tag_v_q[NSTG-1] & ~tag_dbl_q[NSTG-1])) |
                (d_rdy != (tag_v_q[NSTG-1] &  tag_dbl_q[NSTG-1]));
  end

  // Result storage; contents need no reset since the head is masked when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= push_data;
      mem_tid_q[wr_ptr_q]  <= tag_tid_q[NSTG-1];
      mem_cexc_q[wr_ptr_q] <= push_cexc;
    end
  end

  // FIFO pointers and occupancy; credit guarantees no push when full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky protocol error; converter rdy is undefined in the first cycle out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= 1'b1;
      err_q  <= 1'b0;
    end else begin
      mask_q <= 1'b0;
      if (!mask_q && rdy_bad) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_toi_seq.sv
// Self-checking bench for fp_toi_seq with behavioural 6-cycle converter models.
module tb_fp_toi_seq;
  localparam int unsigned TID_W = 5;
  localparam int unsigned DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, req_dbl;
  logic [TID_W-1:0] req_tid;
  logic [63:0]      req_op;
  logic             s_en, d_en;
  logic [31:0]      s_din;
  logic [63:0]      d_din;
  logic [31:0]      s_dout, d_dout;
  logic             s_rdy, s_ovf, s_inv, d_rdy, d_ovf, d_inv;
  logic             res_valid, res_ready;
  logic [TID_W-1:0] res_tid;
  logic [31:0]      res_data;
  logic [4:0]       res_cexc;
  logic             err;

  fp_toi_seq #(.TID_W(TID_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_dbl(req_dbl),
    .req_tid(req_tid), .req_op(req_op),
    .s_en(s_en), .s_din(s_din), .s_dout(s_dout), .s_rdy(s_rdy), .s_ovf(s_ovf), .s_inv(s_inv),
    .d_en(d_en), .d_din(d_din), .d_dout(d_dout), .d_rdy(d_rdy), .d_ovf(d_ovf), .d_inv(d_inv),
    .res_valid(res_valid), .res_ready(res_ready), .res_tid(res_tid),
    .res_data(res_data), .res_cexc(res_cexc), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] data; logic ovf; logic inv;} cvt_t;

  // Float to int32, round toward zero, SPARC saturation on NaN/inf/overflow.
  function automatic cvt_t f2i(input logic [63:0] op, input bit dbl);
    cvt_t r;
    bit sgn;
    int e, emax, bias, fb, ue;
    longint unsigned frac, sig, mag;
    r = '0;
    if (dbl) begin
      sgn = op[63]; e = int'(op[62:52]); emax = 2047; bias = 1023; fb = 52;
      frac = {12'd0, op[51:0]};
    end else begin
      sgn = op[31]; e = int'(op[30:23]); emax = 255; bias = 127; fb = 23;
      frac = {41'd0, op[22:0]};
    end
    sig = frac | (64'd1 << fb);
    ue  = e - bias;
    if (e == emax) begin
      r.inv  = 1'b1;
      r.data = (sgn && frac == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (ue < 0) begin
      r.data = 32'd0;
    end else if (ue > 31) begin
      r.ovf  = 1'b1;
      r.data = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      mag = (ue >= fb) ? (sig << (ue - fb)) : (sig >> (fb - ue));
      if (mag > 64'h8000_0000 || (mag == 64'h8000_0000 && !sgn)) begin
        r.ovf  = 1'b1;
        r.data = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        r.data = sgn ? (~mag[31:0] + 32'd1) : mag[31:0];
      end
    end
    return r;
  endfunction

  // Converter models: fixed 6-cycle pipelines, reset by the shared rst.
  cvt_t s_pipe [6];
  cvt_t d_pipe [6];
  logic [5:0] s_pv, d_pv;
  logic inj_s = 1'b0, inj_d = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_pv <= '0;
      d_pv <= '0;
    end else begin
      s_pv <= {s_pv[4:0], s_en};
      d_pv <= {d_pv[4:0], d_en};
      s_pipe[0] <= f2i({32'd0, s_din}, 1'b0);
      d_pipe[0] <= f2i(d_din, 1'b1);
      for (int i = 1; i < 6; i++) begin
        s_pipe[i] <= s_pipe[i-1];
        d_pipe[i] <= d_pipe[i-1];
      end
    end
  end

  assign s_rdy  = s_pv[5] | inj_s;
  assign s_dout = s_pipe[5].data;
  assign s_ovf  = s_pipe[5].ovf;
  assign s_inv  = s_pipe[5].inv;
  assign d_rdy  = d_pv[5] | inj_d;
  assign d_dout = d_pipe[5].data;
  assign d_ovf  = d_pipe[5].ovf;
  assign d_inv  = d_pipe[5].inv;

  // Reference: every accepted op is owed to the consumer, in order, 7 cycles later.
  typedef struct {
    int unsigned      c;
    logic [TID_W-1:0] tid;
    logic [31:0]      data;
    logic [4:0]       cexc;
  } sb_t;
  sb_t exp_q [$];

  typedef struct {
    bit               dbl;
    logic [TID_W-1:0] tid;
    logic [63:0]      op;
    logic [31:0]      data;
    logic [4:0]       cexc;
  } vec_t;
  vec_t tbl [11];

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int unsigned dut_acc = 0;
  bit          expect_err = 1'b0;
  bit               dm_s;
  logic [31:0]      dm_d;
  logic [TID_W-1:0] dm_t;
  logic [4:0]       dm_c;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: check registered outputs, drive inputs, check steering, update model.
  task automatic cycle(input bit v, input bit dbl, input logic [TID_W-1:0] tid,
                       input logic [63:0] op, input bit rr,
                       output bit seen, output logic [31:0] sd,
                       output logic [TID_W-1:0] st, output logic [4:0] sc);
    bit ev, er;
    sb_t e;
    cvt_t r;
    @(negedge clk);
    ev = (exp_q.size() > 0) && (exp_q[0].c + 7 <= cyc);
    er = (exp_q.size() < DEPTH);
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("res_valid", 64'(res_valid), 64'(ev));
    chk("err", 64'(err), 64'(expect_err));
    seen = res_valid; sd = res_data; st = res_tid; sc = res_cexc;
    if (ev) begin
      chk("res_data", 64'(res_data), 64'(exp_q[0].data));
      chk("res_tid", 64'(res_tid), 64'(exp_q[0].tid));
      chk("res_cexc", 64'(res_cexc), 64'(exp_q[0].cexc));
    end
    req_valid = v; req_dbl = dbl; req_tid = tid; req_op = op; res_ready = rr;
    #1;
    chk("s_en", 64'(s_en), 64'(v & er & ~dbl));
    chk("d_en", 64'(d_en), 64'(v & er & dbl));
    if (v) begin
      chk("s_din", 64'(s_din), 64'(op[31:0]));
      chk("d_din", d_din, op);
      if (req_ready) dut_acc++;
    end
    if (v && er) begin
      r = f2i(op, dbl);
      e.c = cyc; e.tid = tid; e.data = r.data;
      e.cexc = (r.ovf | r.inv) ? 5'h10 : 5'h00;
      exp_q.push_back(e);
    end
    if (ev && rr) void'(exp_q.pop_front());
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, rr, dm_s, dm_d, dm_t, dm_c);
  endtask

  function automatic logic [63:0] gen_op(input bit dbl);
    int unsigned k;
    bit sgn;
    logic [63:0] m;
    logic [10:0] ed;
    logic [7:0]  es;
    k = $urandom_range(0, 15);
    sgn = 1'($urandom_range(0, 1));
    m = {$urandom, $urandom};
    if (dbl) begin
      ed = (k == 0) ? 11'h7FF : (k == 1) ? 11'd0 : 11'(1021 + $urandom_range(0, 36));
      return {sgn, ed, m[51:0]};
    end else begin
      es = (k == 0) ? 8'hFF : (k == 1) ? 8'd0 : 8'(125 + $urandom_range(0, 36));
      return {m[63:32], sgn, es, m[22:0]};
    end
  endfunction

  // Check all outputs hold their reset values while rst is high.
  task automatic check_reset_outputs();
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_res_tid", 64'(res_tid), 64'd0);
    chk("rst_res_cexc", 64'(res_cexc), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_s_en", 64'(s_en), 64'd0);
    chk("rst_d_en", 64'(d_en), 64'd0);
  endtask

  // Release reset at a negedge with both rdy lines spuriously high for the masked cycle.
  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; inj_s = 1'b1; inj_d = 1'b1;
    @(posedge clk);
    #1;
    inj_s = 1'b0; inj_d = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0, c1;
    bit found, seen;
    logic [31:0] sd;
    logic [TID_W-1:0] st;
    logic [4:0] sc;
    bit d;

    tbl[0]  = '{1'b0, 5'd3,  64'hDEAD_BEEF_3F80_0000, 32'h0000_0001, 5'h00};
    tbl[1]  = '{1'b1, 5'd7,  64'hC004_0000_0000_0000, 32'hFFFF_FFFE, 5'h00};
    tbl[2]  = '{1'b1, 5'd9,  64'h41E0_0000_0000_0000, 32'h7FFF_FFFF, 5'h10};
    tbl[3]  = '{1'b0, 5'd11, 64'h0000_0000_7F80_0000, 32'h7FFF_FFFF, 5'h10};
    tbl[4]  = '{1'b0, 5'd12, 64'h1234_5678_7FC0_0000, 32'h7FFF_FFFF, 5'h10};
    tbl[5]  = '{1'b0, 5'd13, 64'h0000_0000_FF80_0000, 32'h8000_0000, 5'h10};
    tbl[6]  = '{1'b1, 5'd14, 64'hC1E0_0000_0000_0000, 32'h8000_0000, 5'h00};
    tbl[7]  = '{1'b0, 5'd15, 64'hFFFF_FFFF_BFC0_0000, 32'hFFFF_FFFF, 5'h00};
    tbl[8]  = '{1'b1, 5'd16, 64'h0000_0000_0000_0001, 32'h0000_0000, 5'h00};
    tbl[9]  = '{1'b0, 5'd17, 64'h0000_0000_4F00_0000, 32'h7FFF_FFFF, 5'h10};
    tbl[10] = '{1'b0, 5'd31, 64'h0000_0000_4EFF_FFFF, 32'h7FFF_FF80, 5'h00};

    req_valid = 1'b0; req_dbl = 1'b0; req_tid = '0; req_op = '0; res_ready = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2 req_valid = 1'b1;
    #1 check_reset_outputs();
    @(negedge clk);
    release_reset();

    // Directed conversions with exact 7-cycle latency.
    foreach (tbl[i]) begin
      c0 = cyc;
      cycle(1'b1, tbl[i].dbl, tbl[i].tid, tbl[i].op, 1'b1, seen, sd, st, sc);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
        c1 = cyc;
        cycle(1'b0, 1'b0, '0, '0, 1'b1, seen, sd, st, sc);
        if (seen) begin
          found = 1'b1;
          chk("tbl_latency", 64'(c1 - c0), 64'd7);
          chk("tbl_data", 64'(sd), 64'(tbl[i].data));
          chk("tbl_tid", 64'(st), 64'(tbl[i].tid));
          chk("tbl_cexc", 64'(sc), 64'(tbl[i].cexc));
        end
      end
      if (!found) begin
        tests++; fails++;
        $display("FAIL tbl_timeout: vector %0d got no result, required one within 20 cycles", i);
      end
    end

    // Streaming: alternating single/double at full rate.
    dut_acc = 0;
    for (int i = 0; i < 32; i++) begin
      d = 1'(i % 2);
      cycle(1'b1, d, TID_W'(i), gen_op(d), 1'b1, seen, sd, st, sc);
    end
    chk("stream_accepts", 64'(dut_acc), 64'd32);
    idle(10, 1'b1);

    // Backpressure: exactly DEPTH accepts, then release.
    dut_acc = 0;
    for (int i = 0; i < 14; i++) begin
      d = 1'($urandom_range(0, 1));
      cycle(1'b1, d, TID_W'($urandom), gen_op(d), 1'b0, seen, sd, st, sc);
    end
    chk("bp_accepts", 64'(dut_acc), 64'(DEPTH));
    idle(12, 1'b1);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      d = 1'($urandom_range(0, 1));
      cycle(($urandom_range(0, 9) < 7), d, TID_W'($urandom), gen_op(d),
            ($urandom_range(0, 9) < 6), seen, sd, st, sc);
    end
    idle(20, 1'b1);

    // Spurious rdy from the idle double converter must set a sticky error.
    @(negedge clk);
    inj_d = 1'b1;
    @(posedge clk);
    #1 inj_d = 1'b0;
    expect_err = 1'b1;
    idle(3, 1'b1);

    // Reset with 2 results buffered and 3 ops in flight.
    for (int i = 0; i < 5; i++) begin
      d = 1'(i % 2);
      cycle(1'b1, d, TID_W'(20 + i), gen_op(d), 1'b0, seen, sd, st, sc);
    end
    idle(3, 1'b0);
    @(negedge clk);
    chk("pre_reset_valid", 64'(res_valid), 64'd1);
    rst = 1'b1; req_valid = 1'b1; req_dbl = 1'b0;
    #1 check_reset_outputs();
    exp_q.delete();
    expect_err = 1'b0;
    @(negedge clk);
    #1 check_reset_outputs();
    release_reset();
    idle(10, 1'b1);
    cycle(1'b1, 1'b0, 5'd3, 64'h0000_0000_3F80_0000, 1'b1, seen, sd, st, sc);
    idle(10, 1'b1);
    chk("final_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_toi_seq.md
# fp_toi_seq

Issue/retire sequencer for the FPU float-to-integer conversions (FSTOI/FDTOI). It sits between the FPop dispatch and the `fp_stoi`/`fp_dtoi` converter pipelines. It accepts one tagged request per cycle and steers it to the correct converter. It tracks in-flight operations with its own tag pipe, since converter `rdy` is not trusted, and collects the results into an in-order FIFO with a valid/ready output. Each result carries its thread ID and SPARC current-exception bits.

## Interface
- `TID_W`, default 5: thread-ID width.
- `DEPTH`, default 8: result FIFO depth. Must be a power of 2 and ≥8 for full rate.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high. Shared with both converters.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when both `req_valid` and `req_ready` are high.
- `req_dbl` in 1: 1 = FDTOI (64-bit operand), 0 = FSTOI (operand in `req_op[31:0]`).
- `req_tid` in TID_W: thread ID.
- `req_op` in 64: operand.
- `s_en`/`s_din` out 1/32: fp_stoi issue.
- `s_dout`, `s_rdy`, `s_ovf`, `s_inv` in 32/1/1/1: fp_stoi result.
- `d_en`/`d_din` out 1/64: fp_dtoi issue.
- `d_dout`, `d_rdy`, `d_ovf`, `d_inv` in 32/1/1/1: fp_dtoi result.
- `res_valid` out 1: FIFO head valid.
- `res_ready` in 1: consumer accepts head.
- `res_tid` out TID_W: head thread ID.
- `res_data` out 32: head integer result.
- `res_cexc` out 5: {nv,of,uf,dz,nx}.
- `err` out 1: sticky protocol error.

## Operation
- **Issue (combinational):**
  - `acc = req_valid & req_ready`.
  - `s_en = acc & ~req_dbl`; `d_en = acc & req_dbl`.
  - `s_din = req_op[31:0]`; `d_din = req_op`.
- **Tag pipe:** 6 stages, each holding {v, dbl, tid}.
  - Stage 1 loads {acc, req_dbl, req_tid} every cycle.
  - Stage k loads stage k−1.
  - Stage 6 is the retire point.
- **Retire:** when stage 6 has v=1, push one FIFO entry:
  - data = dbl ? `d_dout` : `s_dout`.
  - tid from the tag.
  - `cexc = {inv|ovf, 4'b0}` of the selected converter. Overflow and NaN/inf both report NV per SPARC; OF, UF, DZ and NX are always 0.
- **Credit:** `inflight` = count of v bits in stages 1–6 (0..6). `req_ready = (DEPTH − fifo_count − inflight) > 0`.
  - Computed from registers only; no combinational path from `res_ready`.
  - A pop frees credit from the next cycle.
  - The credit rule guarantees no push to a full FIFO.
- **FIFO:**
  - `res_valid = (fifo_count != 0)`.
  - Pop when `res_valid & res_ready`.
  - Simultaneous push and pop leaves the count unchanged; the pointers wrap mod DEPTH.
  - Order is strictly issue order across both converters (both have equal latency).
- **err (sticky until reset):** set when the selected converter's `rdy` ≠ stage-6 v&(dbl sel), or when the unselected converter's `rdy` = 1.
  - Checking is masked during the first cycle after `rst` deasserts, while converter `rdy` is undefined.

## Timing
- **Reset values:**
  - `res_valid` = 0, `res_data` = 0, `res_tid` = 0, `res_cexc` = 0, `err` = 0.
  - FIFO pointers and counts = 0; all tag v = 0.
  - `req_ready` = 1 and `s_en`/`d_en` = 0 while `rst` is high.
- **Latency:** handshake in cycle c → converter `rdy` in cycle c+6 → push at end of c+6 → `res_valid` high in cycle c+7 if the FIFO was empty.
- **Throughput:** 1 op/cycle sustained with `res_ready` = 1 and DEPTH ≥ 8.
- **Backpressure:** with `res_ready` = 0, exactly DEPTH ops are accepted, then `req_ready` = 0 until a pop.
- **Reset mid-operation:**
  - All in-flight and buffered ops are discarded immediately.
  - Converters are reset by the same `rst`, so no stale `rdy` arrives.
  - `res_valid` = 0 from assertion onward.

## Test plan
- **Single convert:** FSTOI 0x3F800000, tid=3 → `res_valid` in cycle c+7 with `res_data` = 0x00000001, `res_tid` = 3, `res_cexc` = 0, `err` = 0.
- **Double convert:** FDTOI 0xC004000000000000 (−2.5) → `res_data` = 0xFFFFFFFE, `res_cexc` = 0. Also 0x41E0000000000000 (2^31) → 0x7FFFFFFF, `res_cexc` = 0x10.
- **Single special:** FSTOI 0x7F800000 (+inf) → 0x7FFFFFFF, `res_cexc` = 0x10. FSTOI 0x7FC00000 (NaN) → 0x7FFFFFFF, 0x10.
- **Streaming:** 32 back-to-back requests alternating single/double with `res_ready` = 1 → `req_ready` never drops; results appear in issue order with correct tids; `err` = 0.
- **Backpressure:** hold `res_ready` = 0 with `req_valid` = 1 → exactly 8 accepts, then `req_ready` = 0. Release → 8 in-order results, one per cycle, and `req_ready` returns 1 cycle after the first pop.
- **Reset mid-flight:** assert `rst` with 3 ops in flight and 2 buffered → all outputs at reset values immediately. After release, no stale results appear, `err` = 0, and the next request completes in 7 cycles.
